// File: rtl/bist_scan_controller_pkg.sv
// -----------------------------------------------------------------------------
// bist_scan_controller_pkg
//   Shared definitions for the test-per-scan BIST controller: the state
//   encoding, default geometry of the core under test (b01, 5 scan flops),
//   and a helper used to reject counter widths that would wrap.
// -----------------------------------------------------------------------------
package bist_scan_controller_pkg;

    // 3-bit binary session states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_UNLOAD  = 3'd4,
        ST_COMPARE = 3'd5,
        ST_DONE    = 3'd6
    } bist_state_t;

    // Defaults shared with the LFSR, MISR and top-level wrapper.
    localparam int DEF_CHAIN_LEN  = 5;
    localparam int DEF_N_PATTERNS = 10;
    localparam int DEF_SIG_WIDTH  = 16;
    localparam int DEF_CNT_W      = 8;

    // True when an unsigned counter of 'width' bits can hold 'value'.
    function automatic bit fits_in_width(input int value, input int width);
        if (width >= 31) begin
            return 1'b1;
        end
        return value < (1 << width);
    endfunction

endpackage

// File: rtl/bist_cycle_counter.sv
// -----------------------------------------------------------------------------
// bist_cycle_counter
//   Up-counter with synchronous clear, count enable and a terminal-count flag.
//   Clear has priority over enable. The counter never wraps on its own: the
//   parent decides what happens at the terminal value (clear or stop).
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   clear     in   return count to 0 at the next edge
//   enable    in   increment count at the next edge
//   count     out  current count (CNT_W bits)
//   terminal  out  count equals TERMINAL
// -----------------------------------------------------------------------------
module bist_cycle_counter #(
    parameter int               CNT_W    = 8,
    parameter logic [CNT_W-1:0] TERMINAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == TERMINAL);

endmodule

// File: rtl/bist_scan_controller.sv
// -----------------------------------------------------------------------------
// bist_scan_controller
//   Sequences one test-per-scan BIST session around a scanned core:
//   INIT (seed LFSR, clear MISR), N_PATTERNS x { SHIFT for CHAIN_LEN cycles,
//   CAPTURE for 1 cycle }, UNLOAD for CHAIN_LEN cycles, COMPARE the MISR
//   signature against GOLDEN_SIG, then DONE until the next start.
//   All control outputs are decoded from the state register only.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   session request, honoured in IDLE or DONE only
//   signature    in   current MISR contents (SIG_WIDTH bits)
//   test_mode    out  route CUT I/O to the BIST datapath
//   scan_en      out  CUT scan enable (1 = shift, 0 = capture)
//   lfsr_load    out  load LFSR seed
//   lfsr_en      out  advance LFSR
//   misr_clear   out  clear MISR
//   misr_en      out  compact scan-out into MISR
//   pattern_idx  out  index of the pattern being applied (CNT_W bits)
//   busy         out  session in progress
//   done         out  session finished, held until next start
//   pass         out  final signature matched GOLDEN_SIG (valid with done)
// -----------------------------------------------------------------------------
module bist_scan_controller
    import bist_scan_controller_pkg::*;
#(
    parameter int                   CHAIN_LEN  = DEF_CHAIN_LEN,
    parameter int                   N_PATTERNS = DEF_N_PATTERNS,
    parameter int                   SIG_WIDTH  = DEF_SIG_WIDTH,
    parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = '0,
    parameter int                   CNT_W      = DEF_CNT_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SIG_WIDTH-1:0] signature,
    output logic                 test_mode,
    output logic                 scan_en,
    output logic                 lfsr_load,
    output logic                 lfsr_en,
    output logic                 misr_clear,
    output logic                 misr_en,
    output logic [CNT_W-1:0]     pattern_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 pass
);

    // Refuse to build a controller whose counters could wrap.
    if (CHAIN_LEN < 1 || N_PATTERNS < 1) begin : g_bad_geometry
        $error("bist_scan_controller: CHAIN_LEN and N_PATTERNS must be >= 1");
    end
    if (!fits_in_width(CHAIN_LEN, CNT_W) || !fits_in_width(N_PATTERNS, CNT_W)) begin : g_bad_cnt_w
        $error("bist_scan_controller: CNT_W too narrow for CHAIN_LEN/N_PATTERNS");
    end

    bist_state_t state;
    bist_state_t state_next;

    logic             session_start;
    logic             shifting;
    logic             shift_clear;
    logic             shift_last;
    logic [CNT_W-1:0] shift_cnt;
    logic             pattern_en;
    logic             pattern_last;
    logic [CNT_W-1:0] pattern_cnt;
    logic             pass_q;

    // A request is honoured only from a quiescent state; while busy it is
    // dropped, not queued.
    assign session_start = start && (state == ST_IDLE || state == ST_DONE);

    // SHIFT and UNLOAD both walk the chain, so they share one counter.
    assign shifting    = (state == ST_SHIFT) || (state == ST_UNLOAD);
    assign shift_clear = session_start || (shifting && shift_last);

    // The pattern counter stops on the last pattern so pattern_idx still
    // shows it in UNLOAD, COMPARE and DONE.
    assign pattern_en = (state == ST_CAPTURE) && !pattern_last;

    bist_cycle_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (CNT_W'(CHAIN_LEN - 1))
    ) u_shift_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (shift_clear),
        .enable   (shifting),
        .count    (shift_cnt),
        .terminal (shift_last)
    );

    bist_cycle_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (CNT_W'(N_PATTERNS - 1))
    ) u_pattern_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (session_start),
        .enable   (pattern_en),
        .count    (pattern_cnt),
        .terminal (pattern_last)
    );

    // Only the terminal flag of the shift counter steers the sequence; the
    // raw count is kept visible for debug but has no other consumer.
    logic unused_shift_cnt;
    assign unused_shift_cnt = ^shift_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The verdict is cleared when a session is accepted and registered on the
    // edge that leaves COMPARE, so it can only be 1 while DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pass_q <= 1'b0;
        end else if (session_start) begin
            pass_q <= 1'b0;
        end else if (state == ST_COMPARE) begin
            pass_q <= (signature == GOLDEN_SIG);
        end
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_next = state;
        test_mode  = 1'b0;
        scan_en    = 1'b0;
        lfsr_load  = 1'b0;
        lfsr_en    = 1'b0;
        misr_clear = 1'b0;
        misr_en    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_INIT;
                end
            end
            ST_INIT: begin
                test_mode  = 1'b1;
                lfsr_load  = 1'b1;
                misr_clear = 1'b1;
                busy       = 1'b1;
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                test_mode = 1'b1;
                scan_en   = 1'b1;
                lfsr_en   = 1'b1;
                misr_en   = 1'b1;
                busy      = 1'b1;
                if (shift_last) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                test_mode  = 1'b1;
                busy       = 1'b1;
                state_next = pattern_last ? ST_UNLOAD : ST_SHIFT;
            end
            ST_UNLOAD: begin
                // The LFSR is frozen: only the last capture is shifted out.
                test_mode = 1'b1;
                scan_en   = 1'b1;
                misr_en   = 1'b1;
                busy      = 1'b1;
                if (shift_last) begin
                    state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                test_mode  = 1'b1;
                busy       = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = ST_INIT;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign pattern_idx = pattern_cnt;
    assign pass        = pass_q;

endmodule

// File: tb/tb_bist_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_bist_scan_controller
//   Two controllers share clock, reset, start and signature: the default
//   geometry (5 flops x 10 patterns, golden 0) and the corner geometry
//   (1 flop x 1 pattern, golden A5C3). A timeline model derives every
//   output from the number of edges since the session was accepted.
// -----------------------------------------------------------------------------
module tb_bist_scan_controller;

    localparam int PH_INIT    = 0;
    localparam int PH_SHIFT   = 1;
    localparam int PH_CAPTURE = 2;
    localparam int PH_UNLOAD  = 3;
    localparam int PH_COMPARE = 4;
    localparam int MAX_WAIT   = 100;

    logic        clock     = 1'b0;
    logic        reset     = 1'b0;
    logic        start     = 1'b0;
    logic [15:0] signature = 16'h0000;

    logic       test_mode [2];
    logic       scan_en   [2];
    logic       lfsr_load [2];
    logic       lfsr_en   [2];
    logic       misr_clear[2];
    logic       misr_en   [2];
    logic [7:0] pattern_idx[2];
    logic       busy      [2];
    logic       done      [2];
    logic       pass      [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    bist_scan_controller dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .signature   (signature),
        .test_mode   (test_mode[0]),
        .scan_en     (scan_en[0]),
        .lfsr_load   (lfsr_load[0]),
        .lfsr_en     (lfsr_en[0]),
        .misr_clear  (misr_clear[0]),
        .misr_en     (misr_en[0]),
        .pattern_idx (pattern_idx[0]),
        .busy        (busy[0]),
        .done        (done[0]),
        .pass        (pass[0])
    );

    bist_scan_controller #(
        .CHAIN_LEN  (1),
        .N_PATTERNS (1),
        .GOLDEN_SIG (16'hA5C3)
    ) dut_small (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .signature   (signature),
        .test_mode   (test_mode[1]),
        .scan_en     (scan_en[1]),
        .lfsr_load   (lfsr_load[1]),
        .lfsr_en     (lfsr_en[1]),
        .misr_clear  (misr_clear[1]),
        .misr_en     (misr_en[1]),
        .pattern_idx (pattern_idx[1]),
        .busy        (busy[1]),
        .done        (done[1]),
        .pass        (pass[1])
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int chain_of(input int i);
        return (i == 0) ? 5 : 1;
    endfunction

    function automatic int npat_of(input int i);
        return (i == 0) ? 10 : 1;
    endfunction

    function automatic logic [15:0] golden_of(input int i);
        return (i == 0) ? 16'h0000 : 16'hA5C3;
    endfunction

    // Phase of the cycle that follows edge 'off' after the accepting edge.
    function automatic int phase_of(input int i, input int off);
        int c    = chain_of(i);
        int body = npat_of(i) * (c + 1);
        if (off == 0)        return PH_INIT;
        if (off <= body)     return (((off - 1) % (c + 1)) < c) ? PH_SHIFT : PH_CAPTURE;
        if (off <= body + c) return PH_UNLOAD;
        return PH_COMPARE;
    endfunction

    function automatic int pattern_of(input int i, input int off);
        int c    = chain_of(i);
        int body = npat_of(i) * (c + 1);
        if (off == 0)    return 0;
        if (off <= body) return (off - 1) / (c + 1);
        return npat_of(i) - 1;
    endfunction

    bit m_active[2] = '{0, 0};
    int m_off   [2] = '{0, 0};
    bit m_done  [2] = '{0, 0};
    bit m_pass  [2] = '{0, 0};
    int m_idx   [2] = '{0, 0};

    always @(posedge clock or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_active[i] <= 1'b0;
                m_off[i]    <= 0;
                m_done[i]   <= 1'b0;
                m_pass[i]   <= 1'b0;
                m_idx[i]    <= 0;
            end else if (!m_active[i]) begin
                if (start) begin
                    m_active[i] <= 1'b1;
                    m_off[i]    <= 0;
                    m_done[i]   <= 1'b0;
                    m_pass[i]   <= 1'b0;
                end
            end else if (phase_of(i, m_off[i]) == PH_COMPARE) begin
                m_active[i] <= 1'b0;
                m_done[i]   <= 1'b1;
                m_pass[i]   <= (signature == golden_of(i));
                m_idx[i]    <= npat_of(i) - 1;
            end else begin
                m_off[i] <= m_off[i] + 1;
            end
        end
    end

    // {test_mode, scan_en, lfsr_load, lfsr_en, misr_clear, misr_en, busy, done, pass}
    function automatic logic [8:0] exp_ctl(input int i);
        int ph;
        if (!m_active[i]) return {7'b0, m_done[i], m_pass[i]};
        ph = phase_of(i, m_off[i]);
        case (ph)
            PH_INIT:  return 9'b1_0_1_0_1_0_1_0_0;
            PH_SHIFT: return 9'b1_1_0_1_0_1_1_0_0;
            PH_UNLOAD:return 9'b1_1_0_0_0_1_1_0_0;
            default:  return 9'b1_0_0_0_0_0_1_0_0;
        endcase
    endfunction

    function automatic int exp_idx(input int i);
        return m_active[i] ? pattern_of(i, m_off[i]) : m_idx[i];
    endfunction

    function automatic logic [8:0] act_ctl(input int i);
        return {test_mode[i], scan_en[i], lfsr_load[i], lfsr_en[i], misr_clear[i],
                misr_en[i], busy[i], done[i], pass[i]};
    endfunction

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ctl[%0d]", i), 32'(act_ctl(i)), 32'(exp_ctl(i)));
            check($sformatf("pattern_idx[%0d]", i), 32'(pattern_idx[i]), 32'(exp_idx(i)));
        end
    end

    // Activity counters on the default controller (free running).
    int mon_load = 0, mon_clear = 0, mon_scan = 0, mon_lfsr = 0, mon_misr = 0;
    int mon_busy = 0, mon_scan_rise = 0;
    logic scan_prev = 1'b0;

    always @(negedge clock) begin
        mon_load      <= mon_load  + int'(lfsr_load[0]);
        mon_clear     <= mon_clear + int'(misr_clear[0]);
        mon_scan      <= mon_scan  + int'(scan_en[0]);
        mon_lfsr      <= mon_lfsr  + int'(lfsr_en[0]);
        mon_misr      <= mon_misr  + int'(misr_en[0]);
        mon_busy      <= mon_busy  + int'(busy[0]);
        mon_scan_rise <= mon_scan_rise + int'(scan_en[0] && !scan_prev);
        scan_prev     <= scan_en[0];
    end

    // ---------------- directed helpers ----------------
    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done on the default DUT.
    task automatic run_session(input int repulse_at, output int main_edge,
                               output int small_edge, output int max_idx);
        main_edge  = -1;
        small_edge = -1;
        max_idx    = 0;
        for (int e = 1; e <= MAX_WAIT; e++) begin
            @(posedge clock);
            #1;
            if (e == repulse_at - 1) start = 1'b1;
            if (e == repulse_at)     start = 1'b0;
            if (int'(pattern_idx[0]) > max_idx) max_idx = int'(pattern_idx[0]);
            if (small_edge < 0 && done[1]) small_edge = e;
            if (done[0]) begin
                main_edge = e;
                start = 1'b0;
                break;
            end
        end
    endtask

    int edge_main, edge_small, max_idx;
    int s_load, s_clear, s_scan, s_lfsr, s_misr, s_busy, s_rise;

    initial begin
        // Reset and idle.
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        check("idle_ctl0", 32'(act_ctl(0)), 32'h0);
        check("idle_idx0", 32'(pattern_idx[0]), 32'h0);
        check("idle_ctl1", 32'(act_ctl(1)), 32'h0);

        // Nominal session, signature matches.
        signature = 16'h0000;
        s_load = mon_load; s_clear = mon_clear; s_scan = mon_scan; s_lfsr = mon_lfsr;
        s_misr = mon_misr; s_busy = mon_busy; s_rise = mon_scan_rise;
        pulse_start();
        run_session(-1, edge_main, edge_small, max_idx);
        check("nom_done_edge", 32'(edge_main), 32'd67);
        check("nom_pass", 32'(pass[0]), 32'd1);
        check("nom_lfsr_load_cycles", 32'(mon_load - s_load), 32'd1);
        check("nom_misr_clear_cycles", 32'(mon_clear - s_clear), 32'd1);
        check("nom_scan_en_cycles", 32'(mon_scan - s_scan), 32'd55);
        check("nom_lfsr_en_cycles", 32'(mon_lfsr - s_lfsr), 32'd50);
        check("nom_misr_en_cycles", 32'(mon_misr - s_misr), 32'd55);
        check("nom_busy_cycles", 32'(mon_busy - s_busy), 32'd67);
        check("nom_scan_bursts", 32'(mon_scan_rise - s_rise), 32'd11);
        check("nom_max_idx", 32'(max_idx), 32'd9);
        check("nom_done_idx", 32'(pattern_idx[0]), 32'd9);
        check("small_done_edge", 32'(edge_small), 32'd5);
        check("small_pass", 32'(pass[1]), 32'd0);

        // Signature mismatch, verdict held.
        signature = 16'hBEEF;
        pulse_start();
        run_session(-1, edge_main, edge_small, max_idx);
        check("mis_done_edge", 32'(edge_main), 32'd67);
        check("mis_pass", 32'(pass[0]), 32'd0);
        repeat (20) @(posedge clock);
        #1;
        check("mis_done_held", 32'(done[0]), 32'd1);
        check("mis_pass_held", 32'(pass[0]), 32'd0);

        // start held high for the whole session.
        signature = 16'h0000;
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1;
        run_session(-1, edge_main, edge_small, max_idx);
        check("held_done_edge", 32'(edge_main), 32'd67);
        check("held_pass", 32'(pass[0]), 32'd1);

        // start in DONE restarts; a re-pulse at edge 30 is ignored.
        pulse_start();
        check("restart_done", 32'(done[0]), 32'd0);
        check("restart_pass", 32'(pass[0]), 32'd0);
        check("restart_busy", 32'(busy[0]), 32'd1);
        run_session(30, edge_main, edge_small, max_idx);
        check("repulse_done_edge", 32'(edge_main), 32'd67);

        // Asynchronous reset at edge 40, between edges.
        pulse_start();
        repeat (39) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("async_ctl0", 32'(act_ctl(0)), 32'h0);
        check("async_idx0", 32'(pattern_idx[0]), 32'h0);
        check("async_ctl1", 32'(act_ctl(1)), 32'h0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("post_reset_idle", 32'(act_ctl(0)), 32'h0);
        signature = 16'hA5C3;
        pulse_start();
        run_session(-1, edge_main, edge_small, max_idx);
        check("post_reset_done_edge", 32'(edge_main), 32'd67);
        check("post_reset_pass0", 32'(pass[0]), 32'd0);
        check("post_reset_small_edge", 32'(edge_small), 32'd5);
        check("post_reset_pass1", 32'(pass[1]), 32'd1);

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            @(posedge clock);
            #1;
            start = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       signature = 16'h0000;
                1:       signature = 16'hA5C3;
                default: signature = 16'($urandom);
            endcase
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b0;
                #4 reset = 1'b1;
            end
        end
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
